// File: rtl/pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid_reg
// Brief    : Parametrised pipeline-stage register with valid/ready handshake,
//            optional 2-entry skid buffer, synchronous flush, global freeze
//            and a saturating downstream-stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid_reg #(
   parameter int DATA_W = 32,
   parameter int LANES  = 2,
   parameter int DEST_W = 4,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_wb_en,
   input  logic                    in_mem_r_en,
   input  logic [LANES*DATA_W-1:0] in_data,
   input  logic [DEST_W-1:0]       in_dest,
   input  logic                    freeze,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_wb_en,
   output logic                    out_mem_r_en,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic [DEST_W-1:0]       out_dest,
   output logic [1:0]              occupancy,
   output logic [CNT_W-1:0]        stall_cnt
);

   localparam int               PW        = LANES * DATA_W;
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   // Goes high on the first clock edge after reset release; keeps in_ready
   // low while reset is asserted without a combinational path from rst.
   logic              live_q;

   // Main entry: always the head of the FIFO and the one driving the outputs.
   logic              main_valid_q,  main_valid_d;
   logic              main_wb_en_q,  main_wb_en_d;
   logic              main_mem_r_en_q, main_mem_r_en_d;
   logic [PW-1:0]     main_data_q,   main_data_d;
   logic [DEST_W-1:0] main_dest_q,   main_dest_d;

   // View of the skid entry (tied off when the skid buffer is not built).
   logic              skid_valid;
   logic              skid_wb_en;
   logic              skid_mem_r_en;
   logic [PW-1:0]     skid_data;
   logic [DEST_W-1:0] skid_dest;

   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic              in_fire;
   logic              out_fire;

   // freeze masks out_valid, so every transfer and the stall counter hold.
   assign out_valid    = main_valid_q & ~freeze;
   assign out_fire     = out_valid & out_ready;
   assign in_fire      = in_valid & in_ready;

   // Control bits of a bubble read 0 so the next stage sees no write-back.
   assign out_wb_en    = main_wb_en_q & out_valid;
   assign out_mem_r_en = main_mem_r_en_q & out_valid;
   assign out_data     = main_data_q;
   assign out_dest     = main_dest_q;
   assign occupancy    = {1'b0, main_valid_q} + {1'b0, skid_valid};
   assign stall_cnt    = stall_cnt_q;

   // Main entry next state: refill from skid first to keep FIFO order.
   always_comb begin
      main_valid_d    = main_valid_q;
      main_wb_en_d    = main_wb_en_q;
      main_mem_r_en_d = main_mem_r_en_q;
      main_data_d     = main_data_q;
      main_dest_d     = main_dest_q;
      if (flush) begin
         main_valid_d    = 1'b0;
         main_wb_en_d    = 1'b0;
         main_mem_r_en_d = 1'b0;
      end else if (!main_valid_q || out_fire) begin
         if (skid_valid) begin
            main_valid_d    = 1'b1;
            main_wb_en_d    = skid_wb_en;
            main_mem_r_en_d = skid_mem_r_en;
            main_data_d     = skid_data;
            main_dest_d     = skid_dest;
         end else if (in_fire) begin
            main_valid_d    = 1'b1;
            main_wb_en_d    = in_wb_en;
            main_mem_r_en_d = in_mem_r_en;
            main_data_d     = in_data;
            main_dest_d     = in_dest;
         end else begin
            main_valid_d    = 1'b0;
            main_wb_en_d    = 1'b0;
            main_mem_r_en_d = 1'b0;
         end
      end
   end

   // Stall counter next state: count presented-but-refused cycles, saturate.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid && !out_ready && (stall_cnt_q != c_cnt_max)) begin
         stall_cnt_d = stall_cnt_q + c_cnt_one;
      end
   end

   // Main entry, counter and live flag; reset discards every held packet.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         live_q          <= 1'b0;
         main_valid_q    <= 1'b0;
         main_wb_en_q    <= 1'b0;
         main_mem_r_en_q <= 1'b0;
         main_data_q     <= '0;
         main_dest_q     <= '0;
         stall_cnt_q     <= '0;
      end else begin
         live_q          <= 1'b1;
         main_valid_q    <= main_valid_d;
         main_wb_en_q    <= main_wb_en_d;
         main_mem_r_en_q <= main_mem_r_en_d;
         main_data_q     <= main_data_d;
         main_dest_q     <= main_dest_d;
         stall_cnt_q     <= stall_cnt_d;
      end
   end

   if (SKID != 0) begin : g_skid
      logic              skid_valid_q,    skid_valid_d;
      logic              skid_wb_en_q,    skid_wb_en_d;
      logic              skid_mem_r_en_q, skid_mem_r_en_d;
      logic [PW-1:0]     skid_data_q,     skid_data_d;
      logic [DEST_W-1:0] skid_dest_q,     skid_dest_d;

      // in_ready comes only from flops and freeze, never from out_ready.
      assign in_ready = live_q & ~skid_valid_q & ~freeze;

      // Skid entry catches the packet that arrives while the head is refused.
      always_comb begin
         skid_valid_d    = skid_valid_q;
         skid_wb_en_d    = skid_wb_en_q;
         skid_mem_r_en_d = skid_mem_r_en_q;
         skid_data_d     = skid_data_q;
         skid_dest_d     = skid_dest_q;
         if (flush) begin
            skid_valid_d    = 1'b0;
            skid_wb_en_d    = 1'b0;
            skid_mem_r_en_d = 1'b0;
         end else if (skid_valid_q && out_fire) begin
            skid_valid_d    = 1'b0;
         end else if (in_fire && main_valid_q && !out_fire) begin
            skid_valid_d    = 1'b1;
            skid_wb_en_d    = in_wb_en;
            skid_mem_r_en_d = in_mem_r_en;
            skid_data_d     = in_data;
            skid_dest_d     = in_dest;
         end
      end

      // Skid entry registers.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            skid_valid_q    <= 1'b0;
            skid_wb_en_q    <= 1'b0;
            skid_mem_r_en_q <= 1'b0;
            skid_data_q     <= '0;
            skid_dest_q     <= '0;
         end else begin
            skid_valid_q    <= skid_valid_d;
            skid_wb_en_q    <= skid_wb_en_d;
            skid_mem_r_en_q <= skid_mem_r_en_d;
            skid_data_q     <= skid_data_d;
            skid_dest_q     <= skid_dest_d;
         end
      end

      assign skid_valid    = skid_valid_q;
      assign skid_wb_en    = skid_wb_en_q;
      assign skid_mem_r_en = skid_mem_r_en_q;
      assign skid_data     = skid_data_q;
      assign skid_dest     = skid_dest_q;
   end else begin : g_no_skid
      // Single entry: accept when empty or when the head leaves this cycle.
      assign in_ready      = live_q & (~main_valid_q | out_ready) & ~freeze;
      assign skid_valid    = 1'b0;
      assign skid_wb_en    = 1'b0;
      assign skid_mem_r_en = 1'b0;
      assign skid_data     = '0;
      assign skid_dest     = '0;
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid_reg
// Brief    : Scoreboard bench for pipe_stage_skid_reg. Two instances share
//            one stimulus stream: A has the skid buffer and a 4-bit stall
//            counter, B is single-entry with a 16-bit counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid_reg;

   typedef struct packed {
      logic        wb;
      logic        mem;
      logic [63:0] data;
      logic [3:0]  dest;
   } pkt_t;

   logic        clk;
   logic        rst;
   logic        in_valid, in_wb_en, in_mem_r_en, freeze, flush, out_ready;
   logic [63:0] in_data;
   logic [3:0]  in_dest;

   logic        a_in_ready, a_out_valid, a_out_wb_en, a_out_mem_r_en;
   logic [63:0] a_out_data;
   logic [3:0]  a_out_dest;
   logic [1:0]  a_occupancy;
   logic [3:0]  a_stall;

   logic        b_in_ready, b_out_valid, b_out_wb_en, b_out_mem_r_en;
   logic [63:0] b_out_data;
   logic [3:0]  b_out_dest;
   logic [1:0]  b_occupancy;
   logic [15:0] b_stall;

   int          n_cmp = 0;
   int          n_bad = 0;

   pkt_t        sb0[$];
   pkt_t        sb1[$];
   int unsigned exp_stall[2];
   logic        alive_m;

   pipe_stage_skid_reg #(.DATA_W(32), .LANES(2), .DEST_W(4), .SKID(1), .CNT_W(4)) u_skid (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(a_in_ready),
      .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en),
      .in_data(in_data), .in_dest(in_dest),
      .freeze(freeze), .flush(flush),
      .out_valid(a_out_valid), .out_ready(out_ready),
      .out_wb_en(a_out_wb_en), .out_mem_r_en(a_out_mem_r_en),
      .out_data(a_out_data), .out_dest(a_out_dest),
      .occupancy(a_occupancy), .stall_cnt(a_stall)
   );

   pipe_stage_skid_reg #(.DATA_W(32), .LANES(2), .DEST_W(4), .SKID(0), .CNT_W(16)) u_noskid (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(b_in_ready),
      .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en),
      .in_data(in_data), .in_dest(in_dest),
      .freeze(freeze), .flush(flush),
      .out_valid(b_out_valid), .out_ready(out_ready),
      .out_wb_en(b_out_wb_en), .out_mem_r_en(b_out_mem_r_en),
      .out_data(b_out_data), .out_dest(b_out_dest),
      .occupancy(b_occupancy), .stall_cnt(b_stall)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int sb_size(input int k);
      return (k == 0) ? sb0.size() : sb1.size();
   endfunction

   function automatic pkt_t sb_front(input int k);
      return (k == 0) ? sb0[0] : sb1[0];
   endfunction

   task automatic sb_pop(input int k);
      pkt_t p;
      if (k == 0) p = sb0.pop_front();
      else        p = sb1.pop_front();
   endtask

   task automatic sb_push(input int k, input pkt_t p);
      if (k == 0) sb0.push_back(p);
      else        sb1.push_back(p);
   endtask

   task automatic sb_clear(input int k);
      if (k == 0) sb0.delete();
      else        sb1.delete();
   endtask

   // Ready exists from the first clock edge after reset release.
   always @(posedge clk or posedge rst) begin
      if (rst) alive_m <= 1'b0;
      else     alive_m <= 1'b1;
   end

   // Monitor: compare one instance against the queue model, pop on output fire.
   task automatic mon_dut(input int k, input bit skid, input logic ir, input logic ov,
                          input logic wb, input logic mem, input logic [63:0] d,
                          input logic [3:0] dst, input logic [1:0] occ,
                          input logic [15:0] st, input int unsigned stmax);
      string nm;
      int    n;
      pkt_t  f;
      bit    exp_ov, exp_ir;
      nm = (k == 0) ? "skid" : "noskid";
      if (rst) begin
         chk({nm, ".rst_in_ready"}, 64'(ir), 64'd0);
         chk({nm, ".rst_out_valid"}, 64'(ov), 64'd0);
         chk({nm, ".rst_occupancy"}, 64'(occ), 64'd0);
         chk({nm, ".rst_stall"}, 64'(st), 64'd0);
         chk({nm, ".rst_data"}, d, 64'd0);
         sb_clear(k);
         exp_stall[k] = 0;
         return;
      end
      n      = sb_size(k);
      exp_ov = (n > 0) && !freeze;
      exp_ir = alive_m && !freeze && (skid ? (n < 2) : ((n == 0) || out_ready));
      chk({nm, ".in_ready"}, 64'(ir), 64'(exp_ir));
      chk({nm, ".out_valid"}, 64'(ov), 64'(exp_ov));
      chk({nm, ".occupancy"}, 64'(occ), 64'(n));
      chk({nm, ".stall_cnt"}, 64'(st), 64'(exp_stall[k]));
      if (n > 0) begin
         f = sb_front(k);
         chk({nm, ".out_data"}, d, f.data);
         chk({nm, ".out_dest"}, 64'(dst), 64'(f.dest));
      end
      chk({nm, ".out_wb_en"}, 64'(wb), exp_ov ? 64'(f.wb) : 64'd0);
      chk({nm, ".out_mem_r_en"}, 64'(mem), exp_ov ? 64'(f.mem) : 64'd0);
      if (exp_ov && out_ready) sb_pop(k);
      if (exp_ov && !out_ready && exp_stall[k] < stmax) exp_stall[k]++;
   endtask

   always @(negedge clk) begin
      mon_dut(0, 1'b1, a_in_ready, a_out_valid, a_out_wb_en, a_out_mem_r_en,
              a_out_data, a_out_dest, a_occupancy, {12'h000, a_stall}, 15);
      mon_dut(1, 1'b0, b_in_ready, b_out_valid, b_out_wb_en, b_out_mem_r_en,
              b_out_data, b_out_dest, b_occupancy, b_stall, 65535);
   end

   // Acceptor: push every accepted packet as an expected output; flush empties.
   always begin
      @(negedge clk);
      #1;
      if (rst || flush) begin
         sb_clear(0);
         sb_clear(1);
      end else if (in_valid) begin
         if (a_in_ready) sb_push(0, '{wb: in_wb_en, mem: in_mem_r_en, data: in_data, dest: in_dest});
         if (b_in_ready) sb_push(1, '{wb: in_wb_en, mem: in_mem_r_en, data: in_data, dest: in_dest});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #2;
   endtask

   task automatic send(input logic wb, input logic mem, input logic [3:0] dst, input logic [63:0] d);
      in_valid    = 1'b1;
      in_wb_en    = wb;
      in_mem_r_en = mem;
      in_dest     = dst;
      in_data     = d;
   endtask

   // Entered at posedge+1; asserts rst mid-cycle, returns with both DUTs live.
   task automatic do_reset();
      #2 rst = 1'b1;
      sample();
      chk("reset_mid.skid_occupancy", 64'(a_occupancy), 64'd0);
      chk("reset_mid.skid_out_valid", 64'(a_out_valid), 64'd0);
      chk("reset_mid.noskid_occupancy", 64'(b_occupancy), 64'd0);
      chk("reset_mid.noskid_stall", 64'(b_stall), 64'd0);
      @(posedge clk);
      #3 rst = 1'b0;
      step();
   endtask

   initial begin
      rst = 1'b0;
      in_valid = 1'b0; in_wb_en = 1'b0; in_mem_r_en = 1'b0;
      in_data = '0; in_dest = '0;
      freeze = 1'b0; flush = 1'b0; out_ready = 1'b0;
      exp_stall[0] = 0;
      exp_stall[1] = 0;
      #1 rst = 1'b1;
      repeat (3) step();
      #2 rst = 1'b0;
      step();

      // 1: single packet appears one cycle after acceptance
      out_ready = 1'b1;
      send(1'b1, 1'b0, 4'h5, {32'hCAFE_0001, 32'h0000_1234});
      step();
      in_valid = 1'b0;
      sample();
      chk("t1.skid_out_valid", 64'(a_out_valid), 64'd1);
      chk("t1.skid_out_dest", 64'(a_out_dest), 64'd5);
      chk("t1.skid_lane0", 64'(a_out_data[31:0]), 64'h1234);
      chk("t1.skid_occupancy", 64'(a_occupancy), 64'd1);
      chk("t1.noskid_lane0", 64'(b_out_data[31:0]), 64'h1234);
      step();

      // 2: skid fills behind a refused head, then drains in order
      out_ready = 1'b0;
      send(1'b1, 1'b1, 4'h1, 64'hAAAA_0000_0000_0001);
      step();
      send(1'b0, 1'b1, 4'h2, 64'hBBBB_0000_0000_0002);
      step();
      in_valid = 1'b0;
      sample();
      chk("t2.skid_occupancy_full", 64'(a_occupancy), 64'd2);
      chk("t2.skid_in_ready_full", 64'(a_in_ready), 64'd0);
      chk("t2.skid_head_A", 64'(a_out_dest), 64'd1);
      chk("t2.noskid_occupancy", 64'(b_occupancy), 64'd1);
      step();
      out_ready = 1'b1;
      sample();
      chk("t2.skid_A_out", a_out_data, 64'hAAAA_0000_0000_0001);
      step();
      sample();
      chk("t2.skid_B_out", a_out_data, 64'hBBBB_0000_0000_0002);
      chk("t2.skid_in_ready_back", 64'(a_in_ready), 64'd1);
      chk("t2.noskid_empty", 64'(b_out_valid), 64'd0);
      step();

      // asynchronous reset with packets in flight
      out_ready = 1'b0;
      send(1'b1, 1'b0, 4'h7, 64'h7777);
      step();
      send(1'b1, 1'b0, 4'h8, 64'h8888);
      step();
      in_valid = 1'b0;
      do_reset();

      // 3: freeze hides the held packet and stops the counter
      send(1'b1, 1'b0, 4'h9, 64'h9999_0000_1111_2222);
      step();
      in_valid = 1'b0;
      step();
      freeze = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("t3.frozen_out_valid", 64'(a_out_valid), 64'd0);
         chk("t3.frozen_wb_en", 64'(a_out_wb_en), 64'd0);
         chk("t3.frozen_stall", 64'(a_stall), 64'd1);
         step();
      end
      freeze = 1'b0;
      sample();
      chk("t3.thaw_out_valid", 64'(a_out_valid), 64'd1);
      chk("t3.thaw_wb_en", 64'(a_out_wb_en), 64'd1);
      chk("t3.thaw_data", a_out_data, 64'h9999_0000_1111_2222);
      chk("t3.noskid_stall", 64'(b_stall), 64'd1);
      step();

      // 4: flush with two held packets drops a simultaneous input
      out_ready = 1'b0;
      send(1'b1, 1'b0, 4'h3, 64'h3333);
      step();
      send(1'b1, 1'b0, 4'h4, 64'h4444);
      step();
      send(1'b1, 1'b1, 4'hC, 64'hCCCC);
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      sample();
      chk("t4.skid_occupancy", 64'(a_occupancy), 64'd0);
      chk("t4.skid_out_valid", 64'(a_out_valid), 64'd0);
      chk("t4.noskid_occupancy", 64'(b_occupancy), 64'd0);
      step();
      sample();
      chk("t4.skid_input_dropped", 64'(a_occupancy), 64'd0);
      step();

      // 5: 4-bit counter saturates, 16-bit counter shows the exact count
      do_reset();
      send(1'b0, 1'b1, 4'hE, 64'hEEEE);
      step();
      in_valid = 1'b0;
      repeat (20) step();
      sample();
      chk("t5.skid_stall_sat", 64'(a_stall), 64'hF);
      chk("t5.noskid_stall_20", 64'(b_stall), 64'd20);
      step();
      out_ready = 1'b1;
      step();

      // 6: random traffic, ordering checked by the scoreboard
      for (int c = 0; c < 10000; c++) begin
         in_valid    = ($urandom_range(0, 99) < ((c < 5000) ? 70 : 40));
         in_wb_en    = $urandom_range(0, 1) != 0;
         in_mem_r_en = $urandom_range(0, 1) != 0;
         in_data     = {$urandom(), $urandom()};
         in_dest     = 4'($urandom_range(0, 15));
         freeze      = ($urandom_range(0, 15) == 0);
         flush       = ($urandom_range(0, 31) == 0);
         out_ready   = ($urandom_range(0, 99) < ((c < 5000) ? 50 : 85));
         step();
      end

      in_valid  = 1'b0;
      freeze    = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (5) step();
      sample();
      chk("end.skid_drained", 64'(a_occupancy), 64'd0);
      chk("end.noskid_drained", 64'(b_occupancy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
